// File: rtl/imem_boot_arbiter_if.sv
// Bundle of loader stream, CPU fetch port and Imem port around the boot arbiter.
interface imem_boot_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  // loader stream
  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  // fetch stage
  logic [31:0]       cpu_pc;
  logic [DATA_W-1:0] cpu_instr;
  logic              cpu_stall;
  logic              cpu_run;
  // Imem single port
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // status
  logic [ADDR_W:0]   load_count;
  logic              error;

  // arbiter side
  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last, cpu_pc, mem_rdata,
    output ld_ready, cpu_instr, cpu_stall, cpu_run, mem_addr, mem_we, mem_wdata,
           load_count, error
  );

  // loader / fetch / memory environment side
  modport master (
    output ld_start, ld_valid, ld_data, ld_last, cpu_pc, mem_rdata,
    input  ld_ready, cpu_instr, cpu_stall, cpu_run, mem_addr, mem_we, mem_wdata,
           load_count, error
  );
endinterface

// File: rtl/imem_boot_arbiter.sv
// Shares the single Imem port: loads a program from word 0, then serves CPU fetches.
module imem_boot_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  imem_boot_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [ADDR_W-1:0] WPTR_LAST = '1;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0]  load_count_q, load_count_d;
  logic              error_q, error_d;

  logic              xfer_c;
  logic [ADDR_W-1:0] pc_idx_c;
  logic              pc_ok_c;

  // A word is taken only in LOAD and never in the cycle a restart is requested
  assign xfer_c   = (state_q == ST_LOAD) && !bus.ld_start && bus.ld_valid;
  assign pc_idx_c = bus.cpu_pc[ADDR_W+1:2];
  // Fetch is served only for aligned, in-range addresses inside the loaded program
  assign pc_ok_c  = (bus.cpu_pc[1:0] == 2'b00) &&
                    (bus.cpu_pc[31:ADDR_W+2] == '0) &&
                    ({1'b0, pc_idx_c} < load_count_q);

  // State, write pointer, word count and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wptr_q       <= '0;
      load_count_q <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      load_count_q <= load_count_d;
      error_q      <= error_d;
    end
  end

  // Next state: restart wins over everything, else advance on each accepted word
  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    load_count_d = load_count_q;
    error_d      = error_q;
    if (bus.ld_start) begin
      state_d      = ST_LOAD;
      wptr_d       = '0;
      load_count_d = '0;
      error_d      = 1'b0;
    end else if (xfer_c) begin
      wptr_d       = wptr_q + ADDR_W'(1);
      load_count_d = load_count_q + CNT_W'(1);
      if (bus.ld_last) begin
        state_d = ST_RUN;
      end else if (wptr_q == WPTR_LAST) begin
        state_d = ST_ERR;
        error_d = 1'b1;
      end
    end
  end

  // Port steering: loader owns the memory in LOAD, fetch owns it in RUN
  always_comb begin
    bus.ld_ready   = (state_q == ST_LOAD) && !bus.ld_start;
    bus.cpu_run    = (state_q == ST_RUN);
    bus.cpu_stall  = (state_q != ST_RUN);
    bus.mem_we     = xfer_c;
    bus.mem_wdata  = bus.ld_data;
    bus.mem_addr   = '0;
    bus.cpu_instr  = '0;
    bus.load_count = load_count_q;
    bus.error      = error_q;
    case (state_q)
      ST_LOAD: bus.mem_addr = wptr_q;
      ST_RUN: begin
        bus.mem_addr = pc_idx_c;
        if (pc_ok_c) bus.cpu_instr = bus.mem_rdata;
      end
      default: bus.mem_addr = '0;
    endcase
  end
endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Self-checking bench for imem_boot_arbiter against a behavioural loader/fetch model.
module tb_imem_boot_arbiter;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int          DEPTH  = 256;

  logic clk = 1'b0;
  logic reset;

  imem_boot_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_boot_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Imem array: one write port, combinational read
  logic [DATA_W-1:0] imem [DEPTH];
  always @(posedge clk) if (bus.mem_we) imem[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = imem[bus.mem_addr];

  // Reference model: what has been loaded and what the arbiter is doing
  logic [31:0] m_mem [DEPTH];
  int          m_count;
  bit          m_loading, m_running, m_error;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_count   = 0;
    m_loading = 0;
    m_running = 0;
    m_error   = 0;
  endtask

  // One clock cycle: drive after negedge, check combinational outputs, then clock the model
  task automatic cyc(input bit st, input bit v, input bit last, input logic [31:0] d,
                     input logic [31:0] pc);
    bit          e_ready, e_xfer;
    logic [31:0] e_instr;
    logic [7:0]  e_addr;
    bus.ld_start = st;
    bus.ld_valid = v;
    bus.ld_last  = last;
    bus.ld_data  = d;
    bus.cpu_pc   = pc;
    #1;
    e_ready = m_loading && !st;
    e_xfer  = e_ready && v;
    if (m_running && pc % 4 == 0 && pc < 4 * DEPTH && int'(pc / 4) < m_count)
      e_instr = m_mem[pc / 4];
    else
      e_instr = 32'h0;
    if (m_loading)      e_addr = 8'(m_count);
    else if (m_running) e_addr = 8'(pc / 4);
    else                e_addr = 8'h0;
    chk("ld_ready",   bus.ld_ready,   e_ready);
    chk("mem_we",     bus.mem_we,     e_xfer);
    chk("mem_addr",   bus.mem_addr,   e_addr);
    if (e_xfer) chk("mem_wdata", bus.mem_wdata, d);
    chk("cpu_run",    bus.cpu_run,    m_running);
    chk("cpu_stall",  bus.cpu_stall,  !m_running);
    chk("cpu_instr",  bus.cpu_instr,  e_instr);
    chk("load_count", bus.load_count, m_count);
    chk("error",      bus.error,      m_error);
    @(posedge clk);
    if (st) begin
      m_loading = 1; m_running = 0; m_error = 0; m_count = 0;
    end else if (e_xfer) begin
      m_mem[m_count] = d;
      m_count++;
      if (last) begin
        m_loading = 0; m_running = 1;
      end else if (m_count == DEPTH) begin
        m_loading = 0; m_error = 1;
      end
    end
    @(negedge clk);
  endtask

  // Mix of in-program, beyond-count, misaligned and out-of-range fetch addresses
  function automatic logic [31:0] rand_pc();
    case ($urandom_range(0, 3))
      0, 1: return 32'($urandom_range(0, m_count + 3)) << 2;
      2:    return (32'($urandom_range(0, m_count)) << 2) | 32'($urandom_range(1, 3));
      default: return $urandom;
    endcase
  endfunction

  // Start a session and stream n words with random bubbles
  task automatic load_seq(input int n, input bit give_last, input int gap_pct);
    int sent = 0;
    bit v;
    cyc(1, 0, 0, $urandom, rand_pc());
    while (sent < n) begin
      v = ($urandom_range(0, 99) >= gap_pct);
      cyc(0, v, v && give_last && (sent == n - 1), $urandom, rand_pc());
      if (v) sent++;
    end
  endtask

  task automatic run_fetch(input int n);
    for (int i = 0; i < n; i++)
      cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, rand_pc());
  endtask

  // Asynchronous reset: outputs must react without a clock edge
  task automatic rst_pulse();
    bus.ld_start = 0;
    bus.ld_valid = 0;
    bus.ld_last  = 0;
    reset = 1;
    #1;
    model_reset();
    chk("rst_load_count", bus.load_count, 0);
    chk("rst_ld_ready",   bus.ld_ready,   0);
    chk("rst_cpu_stall",  bus.cpu_stall,  1);
    chk("rst_cpu_run",    bus.cpu_run,    0);
    chk("rst_error",      bus.error,      0);
    chk("rst_mem_we",     bus.mem_we,     0);
    chk("rst_cpu_instr",  bus.cpu_instr,  0);
    @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  bit pat [7];

  initial begin
    bus.ld_start = 0; bus.ld_valid = 0; bus.ld_last = 0;
    bus.ld_data = '0; bus.cpu_pc = '0;
    @(negedge clk);
    rst_pulse();
    run_fetch(3);

    // T1: ten words back-to-back, then fetch W6 and the T3 corner addresses
    load_seq(10, 1, 0);
    cyc(0, 0, 0, 0, 32'h18);
    chk("t1_w6", bus.load_count, 10);
    cyc(0, 0, 0, 0, 32'h28);
    cyc(0, 0, 0, 0, 32'h1A);
    cyc(0, 0, 0, 0, 32'h400);
    cyc(0, 0, 0, 0, 32'h24);
    run_fetch(20);

    // T2: valid pattern 1,0,0,1,1,0,1 gives four contiguous writes
    pat = '{1, 0, 0, 1, 1, 0, 1};
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, pat[i], i == 6, $urandom, 0);
    chk("t2_count", bus.load_count, 4);
    run_fetch(10);

    // Randomized sessions
    for (int s = 0; s < 6; s++) begin
      load_seq($urandom_range(1, 40), 1, 30);
      run_fetch(25);
    end

    // T4: fill memory without ld_last, then restart
    load_seq(256, 0, 0);
    chk("t4_error", bus.error, 1);
    run_fetch(5);
    load_seq(3, 1, 20);
    run_fetch(8);

    // T5: reset after three words, then a fresh two-word load
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, $urandom, 0);
    rst_pulse();
    run_fetch(2);
    load_seq(2, 1, 0);
    run_fetch(6);

    // T6: restart from RUN with valid high, next word lands at address 0
    cyc(1, 1, 0, $urandom, 32'h0);
    cyc(0, 1, 1, $urandom, 32'h0);
    run_fetch(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
